// File: rtl/usb_port_arbiter_if.sv
// Bus bundle between the requesters, the port arbiter and the USB controller's
// register slave port. The master modport is the arbiter's view: it consumes
// requests and slave responses and drives the shared USB register port.
interface usb_port_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ*8-1:0]  req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_read;
  logic [NUM_REQ-1:0]    req_write;
  logic [31:0]           req_rdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_err;
  logic [7:0]            usb_addr;
  logic [31:0]           usb_wdata;
  logic                  usb_read;
  logic                  usb_write;
  logic [31:0]           usb_rdata;
  logic                  usb_ready;
  logic                  usb_configured;

  modport master (
    input  req_addr, req_wdata, req_read, req_write,
    input  usb_rdata, usb_ready, usb_configured,
    output req_rdata, req_ready, req_err,
    output usb_addr, usb_wdata, usb_read, usb_write
  );

  modport slave (
    output req_addr, req_wdata, req_read, req_write,
    output usb_rdata, usb_ready, usb_configured,
    input  req_rdata, req_ready, req_err,
    input  usb_addr, usb_wdata, usb_read, usb_write
  );
endinterface

// File: rtl/usb_port_arbiter.sv
// Round-robin arbiter/sequencer sharing the USB controller register port
// among NUM_REQ requesters. One transaction at a time; grants are held until
// the slave answers or the watchdog expires. Requesters flagged in
// CFG_GATE_MASK only win arbitration while the device is configured.
module usb_port_arbiter #(
  parameter int         NUM_REQ       = 2,
  parameter int         TIMEOUT_CYC   = 255,
  parameter logic [7:0] CFG_GATE_MASK = 8'h02
) (
  input  logic               clk,
  input  logic               rst_n,
  usb_port_arbiter_if.master bus,
  output logic               busy,
  output logic [2:0]         grant_idx,
  output logic [7:0]         timeout_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  LAST_REQ = 3'(NUM_REQ - 1);

  // Requests padded out to 8 slots so a 3-bit index selects without width games.
  logic [7:0]         rd_vec;
  logic [7:0]         wr_vec;
  logic [7:0]         elig_vec;
  logic [7:0]         addr_arr  [8];
  logic [31:0]        wdata_arr [8];
  logic [NUM_REQ-1:0] win_onehot;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [2:0]         winner;
  logic [2:0]         cand;
  logic               any_elig;

  state_t             state;
  logic [2:0]         last_grant;
  logic [15:0]        wd_cnt;
  logic [31:0]        rdata_hold;
  logic [NUM_REQ-1:0] ready_pulse;
  logic [NUM_REQ-1:0] err_pulse;
  logic [7:0]         addr_lat;
  logic [31:0]        wdata_lat;
  logic               rd_strobe;
  logic               wr_strobe;

  for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
    if (gi < NUM_REQ) begin : g_used
      assign rd_vec[gi]    = bus.req_read[gi];
      assign wr_vec[gi]    = bus.req_write[gi];
      assign addr_arr[gi]  = bus.req_addr[8*gi +: 8];
      assign wdata_arr[gi] = bus.req_wdata[32*gi +: 32];
    end else begin : g_pad
      assign rd_vec[gi]    = 1'b0;
      assign wr_vec[gi]    = 1'b0;
      assign addr_arr[gi]  = 8'h00;
      assign wdata_arr[gi] = 32'h0;
    end
    // Gated requesters stay pending but are invisible to arbitration.
    assign elig_vec[gi] = (rd_vec[gi] | wr_vec[gi]) &
                          (~CFG_GATE_MASK[gi] | bus.usb_configured);
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign win_onehot[gi]   = (winner == 3'(gi));
    assign grant_onehot[gi] = (grant_idx == 3'(gi));
  end

  // Round-robin pick: scan from farthest to nearest so the first eligible
  // requester after last_grant is the one left standing.
  always_comb begin
    winner   = last_grant;
    any_elig = 1'b0;
    cand     = 3'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = 3'((int'(last_grant) + k) % NUM_REQ);
      if (elig_vec[cand]) begin
        winner   = cand;
        any_elig = 1'b1;
      end
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_grant  <= LAST_REQ;
      wd_cnt      <= 16'd0;
      rdata_hold  <= 32'h0;
      ready_pulse <= '0;
      err_pulse   <= '0;
      addr_lat    <= 8'h00;
      wdata_lat   <= 32'h0;
      rd_strobe   <= 1'b0;
      wr_strobe   <= 1'b0;
      busy        <= 1'b0;
      grant_idx   <= 3'd0;
      timeout_cnt <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_pulse <= '0;
          err_pulse   <= '0;
          if (any_elig) begin
            grant_idx  <= winner;
            last_grant <= winner;
            addr_lat   <= addr_arr[winner];
            wdata_lat  <= wdata_arr[winner];
            busy       <= 1'b1;
            wd_cnt     <= 16'd0;
            if (rd_vec[winner] && wr_vec[winner]) begin
              // Read and write together is meaningless: reject without touching the slave.
              ready_pulse <= win_onehot;
              err_pulse   <= win_onehot;
              state       <= S_DONE;
            end else begin
              rd_strobe <= rd_vec[winner];
              wr_strobe <= wr_vec[winner];
              state     <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (bus.usb_ready) begin
            if (!wr_strobe) begin
              rdata_hold <= bus.usb_rdata;
            end
            rd_strobe   <= 1'b0;
            wr_strobe   <= 1'b0;
            ready_pulse <= grant_onehot;
            err_pulse   <= '0;
            state       <= S_DONE;
          end else if (wd_cnt == WD_LAST) begin
            rdata_hold  <= 32'hFFFF_FFFF;
            rd_strobe   <= 1'b0;
            wr_strobe   <= 1'b0;
            ready_pulse <= grant_onehot;
            err_pulse   <= grant_onehot;
            if (timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
            state <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        S_DONE: begin
          ready_pulse <= '0;
          err_pulse   <= '0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_rdata = rdata_hold;
  assign bus.req_ready = ready_pulse;
  assign bus.req_err   = err_pulse;
  assign bus.usb_addr  = addr_lat;
  assign bus.usb_wdata = wdata_lat;
  assign bus.usb_read  = rd_strobe;
  assign bus.usb_write = wr_strobe;
endmodule

// File: tb/tb_usb_port_arbiter.sv
// Self-checking bench for usb_port_arbiter: a behavioural USB slave with
// programmable wait states, and a queue of expected completions per scenario.
module tb_usb_port_arbiter;
  localparam int NREQ = 2;
  localparam int TOUT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       busy;
  logic [2:0] grant_idx;
  logic [7:0] timeout_cnt;

  usb_port_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  usb_port_arbiter #(
    .NUM_REQ(NREQ), .TIMEOUT_CYC(TOUT), .CFG_GATE_MASK(8'h02)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy), .grant_idx(grant_idx), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  // Slave model: answers after slave_wait extra cycles, or never when hung.
  int          slave_wait = 0;
  bit          slave_hang = 0;
  logic [31:0] slave_rdata = 32'h0;
  int          slave_cnt = 0;
  logic [7:0]  seen_addr = 8'h00;
  logic [31:0] seen_wdata = 32'h0;
  bit          seen_write = 0;
  int          bus_cycles = 0;

  always @(negedge clk) begin
    if (bus.usb_read || bus.usb_write) begin
      bus.usb_ready = !slave_hang && (slave_cnt == slave_wait);
      bus.usb_rdata = bus.usb_ready ? slave_rdata : 32'hDEAD_BEEF;
      slave_cnt++;
    end else begin
      bus.usb_ready = 1'b0;
      bus.usb_rdata = 32'hDEAD_BEEF;
      slave_cnt = 0;
    end
  end

  always @(posedge clk) begin
    if ((bus.usb_read || bus.usb_write) && bus.usb_ready) begin
      seen_addr  = bus.usb_addr;
      seen_wdata = bus.usb_wdata;
      seen_write = bus.usb_write;
    end
  end

  task automatic wait_ready(input int bound, output bit ok, output int g, output int cycles);
    ok = 0; g = -1; cycles = 0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      cycles++;
      if (bus.usb_read || bus.usb_write) bus_cycles++;
      if (bus.req_ready !== '0) begin
        ok = 1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_read = '0; bus.req_write = '0;
    bus.usb_configured = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.req_rdata, bus.req_ready, bus.req_err, bus.usb_addr, bus.usb_wdata,
         bus.usb_read, bus.usb_write, busy, grant_idx, timeout_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready=%b rdata=%h busy=%b grant=%0d tcnt=%0d required all zero",
               bus.req_ready, bus.req_rdata, busy, grant_idx, timeout_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || bus.req_ready !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle: got busy=%b ready=%b required 0/00", busy, bus.req_ready);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_single_read();
    exp_t e;
    slave_wait = 0; slave_hang = 0; slave_rdata = 32'h05B2_0001;
    bus.req_addr[7:0] = 8'h00; bus.req_read[0] = 1'b1;
    exp_q.push_back('{idx: 0, rdata: 32'h05B2_0001, err: 1'b0, addr: 8'h00, wdata: 32'h0});
    @(negedge clk);  // cycle 1: BUS
    tests_run++;
    if (bus.usb_read !== 1'b1 || bus.usb_write !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_bus: got rd=%b wr=%b busy=%b required 1/0/1", bus.usb_read, bus.usb_write, busy);
    end
    @(negedge clk);  // cycle 2: DONE
    e = exp_q.pop_front();
    tests_run++;
    if (bus.req_ready !== 2'b01 || bus.req_err !== 2'b00 || bus.req_rdata !== e.rdata || bus.usb_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: got ready=%b err=%b rdata=%h rd=%b required 01/00/%h/0",
               bus.req_ready, bus.req_err, bus.req_rdata, bus.usb_read, e.rdata);
    end
    bus.req_read[0] = 1'b0;
    @(negedge clk);  // cycle 3: IDLE
    tests_run++;
    if (bus.req_ready !== 2'b00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle: got ready=%b busy=%b required 00/0", bus.req_ready, busy);
    end
    $display("[TB] single read rdata=%h", bus.req_rdata);
  endtask

  task automatic test_round_robin();
    exp_t e; bit ok; int g; int cyc; logic [31:0] nw;
    slave_wait = 0; slave_hang = 0;
    exp_q.delete();
    bus.req_addr = {8'h21, 8'h10};
    bus.req_wdata = {32'hA1A1_0001, 32'hB0B0_0000};
    bus.req_write = 2'b11;
    // last grant was requester 0, so requester 1 goes first
    exp_q.push_back('{idx: 1, rdata: 32'h0, err: 1'b0, addr: 8'h21, wdata: 32'hA1A1_0001});
    exp_q.push_back('{idx: 0, rdata: 32'h0, err: 1'b0, addr: 8'h10, wdata: 32'hB0B0_0000});
    for (int i = 0; i < 10; i++) begin
      wait_ready(10, ok, g, cyc);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL rr_timeout: got no req_ready required completion %0d", i);
        break;
      end
      e = exp_q.pop_front();
      tests_run++;
      if (g != e.idx || grant_idx !== 3'(e.idx) || seen_write !== 1'b1 ||
          seen_wdata !== e.wdata || seen_addr !== e.addr || bus.req_err !== 2'b00) begin
        tests_failed++;
        $display("FAIL rr_xfer: got g=%0d grant=%0d wdata=%h addr=%h required g=%0d wdata=%h addr=%h",
                 g, grant_idx, seen_wdata, seen_addr, e.idx, e.wdata, e.addr);
      end
      if (i > 0) begin
        tests_run++;
        if (cyc != 3) begin
          tests_failed++;
          $display("FAIL rr_rate: got %0d cycles required 3", cyc);
        end
      end
      $display("[TB] rr %0d grant=%0d wdata=%h", i, g, seen_wdata);
      if (g >= 0) begin
        nw = $urandom;
        bus.req_wdata[g*32 +: 32] = nw;
        exp_q.push_back('{idx: g, rdata: 32'h0, err: 1'b0, addr: e.addr, wdata: nw});
      end
    end
    bus.req_write = 2'b00;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_illegal();
    bit saw_access = 0;
    bus.req_addr[7:0] = 8'h44; bus.req_read[0] = 1'b1; bus.req_write[0] = 1'b1;
    @(negedge clk);
    saw_access = bus.usb_read || bus.usb_write;
    tests_run++;
    if (bus.req_ready !== 2'b01 || bus.req_err !== 2'b01) begin
      tests_failed++;
      $display("FAIL illegal_done: got ready=%b err=%b required 01/01", bus.req_ready, bus.req_err);
    end
    bus.req_read[0] = 1'b0; bus.req_write[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_access = saw_access || bus.usb_read || bus.usb_write;
    end
    tests_run++;
    if (saw_access !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_access: got slave access=%b required 0", saw_access);
    end
    $display("[TB] illegal request rejected");
  endtask

  task automatic test_gating();
    bit seen = 0; bit ok; int g; int cyc; exp_t e;
    slave_wait = 2;
    bus.usb_configured = 1'b0;
    bus.req_addr[15:8] = 8'h33; bus.req_wdata[63:32] = 32'hC0FF_EE11; bus.req_write[1] = 1'b1;
    exp_q.push_back('{idx: 1, rdata: 32'h0, err: 1'b0, addr: 8'h33, wdata: 32'hC0FF_EE11});
    repeat (100) begin
      @(negedge clk);
      seen = seen || busy || (bus.req_ready !== 2'b00);
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL gate_block: got grant/ready while unconfigured required none");
    end
    bus.usb_configured = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || grant_idx !== 3'd1 || bus.usb_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL gate_grant: got busy=%b grant=%0d wr=%b required 1/1/1", busy, grant_idx, bus.usb_write);
    end
    bus.usb_configured = 1'b0;  // falling mid-BUS must not disturb the transfer
    wait_ready(10, ok, g, cyc);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || g != e.idx || bus.req_err !== 2'b00 || seen_wdata !== e.wdata || seen_addr !== e.addr) begin
      tests_failed++;
      $display("FAIL gate_done: got ok=%b g=%0d err=%b wdata=%h required 1/%0d/00/%h",
               ok, g, bus.req_err, seen_wdata, e.idx, e.wdata);
    end
    bus.req_write[1] = 1'b0;
    bus.usb_configured = 1'b1;
    @(negedge clk);
    $display("[TB] gated write grant=%0d wdata=%h", g, seen_wdata);
  endtask

  task automatic test_reset_mid_bus();
    bit ok; int g; int cyc; exp_t e; bit stray = 0;
    slave_wait = 3; slave_rdata = 32'h1234_5678;
    exp_q.delete();
    bus.req_addr[7:0] = 8'h08; bus.req_read[0] = 1'b1;
    repeat (2) @(negedge clk);  // in BUS, waiting on slave
    tests_run++;
    if (bus.usb_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstbus_pre: got rd=%b required 1", bus.usb_read);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.req_rdata, bus.req_ready, bus.req_err, bus.usb_addr, bus.usb_wdata,
         bus.usb_read, bus.usb_write, busy, grant_idx, timeout_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL rstbus_async: got rd=%b busy=%b addr=%h grant=%0d required all zero",
               bus.usb_read, busy, bus.usb_addr, grant_idx);
    end
    repeat (3) begin
      @(negedge clk);
      stray = stray || (bus.req_ready !== 2'b00);
    end
    tests_run++;
    if (stray !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstbus_ready: got req_ready during reset required none");
    end
    slave_wait = 0;
    rst_n = 1'b1;
    bus.req_addr = {8'h99, 8'h88}; bus.req_read = 2'b11;
    exp_q.push_back('{idx: 0, rdata: 32'h1234_5678, err: 1'b0, addr: 8'h88, wdata: 32'h0});
    exp_q.push_back('{idx: 1, rdata: 32'h1234_5678, err: 1'b0, addr: 8'h99, wdata: 32'h0});
    for (int i = 0; i < 2; i++) begin
      wait_ready(10, ok, g, cyc);
      e = exp_q.pop_front();
      tests_run++;
      if (!ok || g != e.idx || bus.req_rdata !== e.rdata || seen_addr !== e.addr) begin
        tests_failed++;
        $display("FAIL rstbus_order: got ok=%b g=%0d rdata=%h addr=%h required 1/%0d/%h/%h",
                 ok, g, bus.req_rdata, seen_addr, e.idx, e.rdata, e.addr);
      end
      if (g >= 0) bus.req_read[g] = 1'b0;
      $display("[TB] after reset served %0d", g);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok; int g; int cyc; int n = 0;
    slave_hang = 1;
    bus.req_addr[7:0] = 8'h5A; bus.req_read[0] = 1'b1;
    bus_cycles = 0;
    wait_ready(20, ok, g, cyc);
    n++;
    tests_run++;
    if (!ok || bus_cycles != TOUT || bus.req_ready !== 2'b01 || bus.req_err !== 2'b01 ||
        bus.req_rdata !== 32'hFFFF_FFFF || timeout_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL timeout_first: got ok=%b buscyc=%0d ready=%b err=%b rdata=%h tcnt=%0d required 1/%0d/01/01/ffffffff/1",
               ok, bus_cycles, bus.req_ready, bus.req_err, bus.req_rdata, timeout_cnt, TOUT);
    end
    $display("[TB] timeout 1 tcnt=%0d", timeout_cnt);
    for (int i = 1; i < 300; i++) begin
      bus.req_read[0] = 1'b0;
      @(negedge clk);
      bus.req_read[0] = 1'b1;
      wait_ready(20, ok, g, cyc);
      if (!ok) begin
        tests_run++; tests_failed++;
        $display("FAIL timeout_loop: got no req_ready required completion %0d", i);
        break;
      end
      n++;
      if (n == 254 || n == 300) begin
        tests_run++;
        if (timeout_cnt !== 8'((n > 255) ? 255 : n) || bus.req_err !== 2'b01) begin
          tests_failed++;
          $display("FAIL timeout_count: got tcnt=%0d err=%b after %0d timeouts required %0d/01",
                   timeout_cnt, bus.req_err, n, (n > 255) ? 255 : n);
        end
        $display("[TB] timeout %0d tcnt=%0d", n, timeout_cnt);
      end
    end
    bus.req_read[0] = 1'b0;
    slave_hang = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_illegal();
    test_gating();
    test_reset_mid_bus();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
